// File: rtl/anti_theft_fsm_pkg.sv
// Shared encodings and default timings for the vehicle anti-theft controller.
// Later reprogramming logic is expected to reuse the T_*_DEF constants.
package anti_theft_fsm_pkg;

    localparam int TIME_W = 4;
    typedef logic [TIME_W-1:0] time_t;

    localparam time_t T_ARM_DEF       = 4'd6;
    localparam time_t T_DRIVER_DEF    = 4'd8;
    localparam time_t T_PASSENGER_DEF = 4'd15;
    localparam time_t T_ALARM_DEF     = 4'd10;

    typedef enum logic [2:0] {
        ST_ARMED          = 3'd0,
        ST_TRIGGERED      = 3'd1,
        ST_SOUND          = 3'd2,
        ST_DISARMED       = 3'd3,
        ST_WAIT_DRV_OPEN  = 3'd4,
        ST_WAIT_DRV_CLOSE = 3'd5,
        ST_ARMING         = 3'd6
    } state_t;

endpackage

// File: rtl/anti_theft_fsm_sec_timer.sv
// Seconds countdown: free-running CLK_HZ divider plus a loadable 4-bit counter.
// start loads value and restarts the divider, so the first tick is CLK_HZ cycles out.
module sec_timer
    import anti_theft_fsm_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TIME_W-1:0] value,
    output logic              tick,
    output logic              expired,
    output logic [TIME_W-1:0] count
);

    localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] div;
    logic             running;

    assign tick    = (div == DIV_LAST);
    assign expired = running && (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            div     <= '0;
            count   <= value;
            running <= 1'b1;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            // Expiry is a single-cycle event; the counter then idles at zero.
            if (expired)
                running <= 1'b0;
            else if (running && tick)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/anti_theft_fsm.sv
// Vehicle anti-theft controller: arming FSM, status LED blink, siren enable and
// hidden-switch fuel-pump interlock, all outputs registered.
module anti_theft_fsm
    import anti_theft_fsm_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter time_t       T_ARM       = T_ARM_DEF,
    parameter time_t       T_DRIVER    = T_DRIVER_DEF,
    parameter time_t       T_PASSENGER = T_PASSENGER_DEF,
    parameter time_t       T_ALARM     = T_ALARM_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       hidden_sw,
    input  logic       brake,
    output logic       status_led,
    output logic       siren,
    output logic       fuel_pump,
    output logic [2:0] state_out,
    output logic [3:0] time_left
);

    state_t state, next_state;
    logic   alarm_timing, next_alarm_timing;
    logic   next_led;
    logic   start;
    time_t  value;
    logic   tick, expired;
    time_t  count;
    logic   any_door;

    sec_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .tick    (tick),
        .expired (expired),
        .count   (count)
    );

    assign any_door  = driver_door || passenger_door;
    assign state_out = state;
    assign time_left = count;

    // Loading zero is the abort: the counter idles at 0 and the single expiry
    // pulse it produces is ignored by whichever state issued it.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state        = state;
        next_alarm_timing = alarm_timing;
        start             = 1'b0;
        value             = '0;

        if (ignition) begin
            next_state        = ST_DISARMED;
            next_alarm_timing = 1'b0;
            start             = (state != ST_DISARMED);
        end else begin
            unique case (state)
                ST_ARMED: if (any_door) begin
                    next_state = ST_TRIGGERED;
                    start      = 1'b1;
                    value      = driver_door ? T_DRIVER : T_PASSENGER;
                end
                ST_TRIGGERED: if (expired) next_state = ST_SOUND;
                ST_SOUND: begin
                    if (any_door) begin
                        next_alarm_timing = 1'b0;
                        start             = alarm_timing;
                    end else if (!alarm_timing) begin
                        next_alarm_timing = 1'b1;
                        start             = 1'b1;
                        value             = T_ALARM;
                    end else if (expired) begin
                        next_state        = ST_ARMED;
                        next_alarm_timing = 1'b0;
                        start             = 1'b1;
                    end
                end
                ST_DISARMED:      next_state = ST_WAIT_DRV_OPEN;
                ST_WAIT_DRV_OPEN: if (driver_door) next_state = ST_WAIT_DRV_CLOSE;
                ST_WAIT_DRV_CLOSE: if (!any_door) begin
                    next_state = ST_ARMING;
                    start      = 1'b1;
                    value      = T_ARM;
                end
                ST_ARMING: begin
                    if (any_door) begin
                        next_state = ST_WAIT_DRV_CLOSE;
                        start      = 1'b1;
                    end else if (expired) begin
                        next_state = ST_ARMED;
                        start      = 1'b1;
                    end
                end
                default: next_state = ST_ARMED;
            endcase
        end
    end

    always_comb begin
        next_led = 1'b0;
        case (next_state)
            ST_ARMED:                next_led = (state == ST_ARMED) && (status_led ^ tick);
            ST_TRIGGERED, ST_SOUND:  next_led = 1'b1;
            default:                 next_led = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_ARMED;
            alarm_timing <= 1'b0;
            status_led   <= 1'b0;
            siren        <= 1'b0;
            fuel_pump    <= 1'b0;
        end else begin
            state        <= next_state;
            alarm_timing <= next_alarm_timing;
            status_led   <= next_led;
            siren        <= (next_state == ST_SOUND);
            fuel_pump    <= ignition && (fuel_pump || (hidden_sw && brake));
        end
    end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed, table-driven bench for anti_theft_fsm at CLK_HZ=10 (1 s = 10 cycles).
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_anti_theft_fsm;

    typedef struct {
        logic       ign, drv, pas, hid, brk;
        int         cyc;
        logic [2:0] st;
        logic [3:0] tl;
        logic       sir, led, fuel;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 1'b0, driver_door = 1'b0, passenger_door = 1'b0;
    logic       hidden_sw = 1'b0, brake = 1'b0;
    logic       status_led, siren, fuel_pump;
    logic [2:0] state_out;
    logic [3:0] time_left;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    anti_theft_fsm #(.CLK_HZ(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .ignition       (ignition),
        .driver_door    (driver_door),
        .passenger_door (passenger_door),
        .hidden_sw      (hidden_sw),
        .brake          (brake),
        .status_led     (status_led),
        .siren          (siren),
        .fuel_pump      (fuel_pump),
        .state_out      (state_out),
        .time_left      (time_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(int ign, int drv, int pas, int hid, int brk, int cyc,
                               int st, int tl, int sir, int led, int fuel);
        vec_t r;
        r.ign = 1'(ign); r.drv = 1'(drv); r.pas = 1'(pas); r.hid = 1'(hid); r.brk = 1'(brk);
        r.cyc = cyc;
        r.st = 3'(st); r.tl = 4'(tl); r.sir = 1'(sir); r.led = 1'(led); r.fuel = 1'(fuel);
        return r;
    endfunction

    task automatic check(string name, logic [2:0] st, logic [3:0] tl,
                         logic sir, logic led, logic fuel);
        n_vec++;
        if ({state_out, time_left, siren, status_led, fuel_pump} !== {st, tl, sir, led, fuel}) begin
            n_err++;
            $display("FAIL %s: got state=%0d time_left=%0d siren=%b led=%b fuel=%b, required state=%0d time_left=%0d siren=%b led=%b fuel=%b",
                     name, state_out, time_left, siren, status_led, fuel_pump,
                     st, tl, sir, led, fuel);
        end
    endtask

    task automatic apply(vec_t x, string name);
        ignition = x.ign; driver_door = x.drv; passenger_door = x.pas;
        hidden_sw = x.hid; brake = x.brk;
        repeat (x.cyc) @(negedge clk);
        check(name, x.st, x.tl, x.sir, x.led, x.fuel);
    endtask

    initial begin
        //                 ign drv pas hid brk cyc   st tl sir led fuel
        // Driver-door trigger, siren, alarm countdown, back to ARMED and blink.
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   1,  8, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,  79,   1,  1, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   1,  0, 0, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   5,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   2, 10, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  99,   2,  1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   0,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   9,   0,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   0,  0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  10,   0,  0, 0, 0, 0));
        // Passenger-only trigger, doors close (no cancel), ignition at 3 s.
        vecs.push_back(v(0, 0, 1, 0, 0,   1,   1, 15, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  30,   1, 12, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0,   1,   3,  0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0,   3,   3,  0, 0, 0, 0));
        // Arming sequence with passenger interruption at 3 s, then blink.
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   4,  0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   5,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   6,  6, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  30,   6,  3, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0,   1,   5,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   6,  6, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  59,   6,  1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   6,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   0,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  10,   0,  0, 0, 1, 0));
        // Both doors on the same cycle pick the driver delay; ignition at 3 s.
        vecs.push_back(v(0, 1, 1, 0, 0,   1,   1,  8, 0, 1, 0));
        vecs.push_back(v(0, 1, 1, 0, 0,  30,   1,  5, 0, 1, 0));
        vecs.push_back(v(1, 1, 1, 0, 0,   1,   3,  0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0,   4,   3,  0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   4,  0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   5,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   6,  6, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  61,   0,  0, 0, 0, 0));
        // SOUND: door reopen at 4 s aborts, closing reloads the full alarm time.
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   1,  8, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  81,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   2, 10, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,  60,   2,  4, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   1,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0,   2,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   2, 10, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 100,   2,  0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   0,  0, 0, 0, 0));
        // Fuel-pump interlock.
        vecs.push_back(v(1, 0, 0, 0, 1,   1,   3,  0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1,   1,   3,  0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0,   3,   3,  0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0,   1,   4,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1,   1,   4,  0, 0, 0, 0));

        repeat (2) @(negedge clk);
        check("reset_hold", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Re-arm and reach SOUND, then assert reset asynchronously mid-cycle.
        apply(v(0, 1, 0, 0, 0,  1, 5, 0, 0, 0, 0), "seq_wclose");
        apply(v(0, 0, 0, 0, 0,  1, 6, 6, 0, 0, 0), "seq_arming");
        apply(v(0, 0, 0, 0, 0, 61, 0, 0, 0, 0, 0), "seq_armed");
        apply(v(0, 1, 0, 0, 0,  1, 1, 8, 0, 1, 0), "seq_trig");
        apply(v(0, 1, 0, 0, 0, 81, 2, 0, 1, 1, 0), "seq_sound");
        #2 reset = 1'b1;
        #1 check("async_reset_sound", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_sound_next", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        driver_door = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("after_release", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset must also clear a latched fuel pump.
        apply(v(1, 0, 0, 1, 1, 1, 3, 0, 0, 0, 1), "fuel_on");
        hidden_sw = 1'b0; brake = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_fuel", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; ignition = 1'b0;
        @(negedge clk);
        check("fuel_stays_off", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
